// File: rtl/decode_pkg.sv
// Shared RV32I decode types: opcodes, ALU/immediate/result encodings and the
// E-stage control bundle carried by the ID/EX register.
package decode_pkg;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    typedef enum logic [3:0] {
        AluAdd   = 4'b0000,
        AluSub   = 4'b0001,
        AluAnd   = 4'b0010,
        AluOr    = 4'b0011,
        AluXor   = 4'b0100,
        AluSlt   = 4'b0101,
        AluSltu  = 4'b0110,
        AluSll   = 4'b0111,
        AluSrl   = 4'b1000,
        AluSra   = 4'b1001,
        AluPassB = 4'b1010
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        ImmI = 3'b000,
        ImmS = 3'b001,
        ImmB = 3'b010,
        ImmJ = 3'b011,
        ImmU = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        ResAlu = 2'b00,
        ResMem = 2'b01,
        ResPc4 = 2'b10
    } result_src_e;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
        logic        jump;
        logic        jalr;
        logic        branch;
        logic [2:0]  funct3;
        alu_ctrl_e   alu_ctrl;
        logic        alu_src_a;
        logic        alu_src_b;
        logic [4:0]  rd;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    // alt selects SUB/SRA; callers decide when funct7[5] is meaningful
    function automatic alu_ctrl_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_ctrl_e a;
        case (f3)
            3'b000:  a = alt ? AluSub : AluAdd;
            3'b001:  a = AluSll;
            3'b010:  a = AluSlt;
            3'b011:  a = AluSltu;
            3'b100:  a = AluXor;
            3'b101:  a = alt ? AluSra : AluSrl;
            3'b110:  a = AluOr;
            default: a = AluAnd;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/rv32i_ctrl_decode.sv
// Combinational RV32I control decoder: full-instruction legality check, E-stage
// control bundle and D-stage immediate select.
module rv32i_ctrl_decode
    import decode_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic [2:0]  imm_src_o,
    output logic        illegal_o
);

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    ctrl_t      c;
    imm_src_e   imm;
    logic       bad;
    logic       unused_instr;

    assign op = instr_i[6:0];
    assign f3 = instr_i[14:12];
    assign f7 = instr_i[31:25];
    assign unused_instr = ^instr_i[24:15];

    always_comb begin
        c          = BUBBLE;
        imm        = ImmI;
        bad        = 1'b0;
        c.valid    = 1'b1;
        c.rd       = instr_i[11:7];
        case (op)
            OpLoad: begin
                bad          = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
                c.reg_write  = 1'b1;
                c.result_src = ResMem;
                c.alu_src_b  = 1'b1;
                c.funct3     = f3;
            end
            OpStore: begin
                bad         = (f3 >= 3'b011);
                imm         = ImmS;
                c.mem_write = 1'b1;
                c.alu_src_b = 1'b1;
                c.funct3    = f3;
            end
            OpR: begin
                bad = !((f7 == 7'b0000000) ||
                        ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
                c.reg_write = 1'b1;
                c.alu_ctrl  = alu_from_funct3(f3, f7[5]);
            end
            OpImm: begin
                if (f3 == 3'b001) begin
                    bad = (f7 != 7'b0000000);
                end else if (f3 == 3'b101) begin
                    bad = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                end
                c.reg_write = 1'b1;
                c.alu_src_b = 1'b1;
                // Only the shift-right form uses funct7[5]; ADDI never subtracts
                c.alu_ctrl  = alu_from_funct3(f3, (f3 == 3'b101) && f7[5]);
            end
            OpBranch: begin
                bad      = (f3 == 3'b010) || (f3 == 3'b011);
                imm      = ImmB;
                c.branch = 1'b1;
                c.funct3 = f3;
                c.alu_ctrl = AluSub;
            end
            OpJal: begin
                imm          = ImmJ;
                c.jump       = 1'b1;
                c.reg_write  = 1'b1;
                c.result_src = ResPc4;
            end
            OpJalr: begin
                bad          = (f3 != 3'b000);
                c.jump       = 1'b1;
                c.jalr       = 1'b1;
                c.reg_write  = 1'b1;
                c.result_src = ResPc4;
                c.alu_src_b  = 1'b1;
            end
            OpLui: begin
                imm         = ImmU;
                c.reg_write = 1'b1;
                c.alu_ctrl  = AluPassB;
                c.alu_src_b = 1'b1;
            end
            OpAuipc: begin
                imm         = ImmU;
                c.reg_write = 1'b1;
                c.alu_src_a = 1'b1;
                c.alu_src_b = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            c         = BUBBLE;
            c.valid   = 1'b1;
            c.illegal = 1'b1;
        end
    end

    assign ctrl_o    = c;
    assign imm_src_o = imm;
    assign illegal_o = bad;

endmodule

// File: rtl/decode_ctrl_stage.sv
// RV32I decode stage control: combinational D-stage outputs, ID/EX control
// register with reset > flush > stall > load priority, saturating illegal counter.
module decode_ctrl_stage
    import decode_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ALU_CTRL_W = 4,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_WIDTH-1:0] instrD,
    input  logic                  validD,
    input  logic                  stallE,
    input  logic                  flushE,
    output logic [2:0]            ImmSrcD,
    output logic                  illegalD,
    output logic                  validE,
    output logic                  regWriteE,
    output logic [1:0]            resultSrcE,
    output logic                  memWriteE,
    output logic                  jumpE,
    output logic                  jalrE,
    output logic                  branchE,
    output logic [2:0]            funct3E,
    output logic [ALU_CTRL_W-1:0] ALUControlE,
    output logic                  ALUSrcAE,
    output logic                  ALUSrcBE,
    output logic [REG_ADDR_W-1:0] rdE,
    output logic                  illegalE,
    output logic [CNT_W-1:0]      illegal_count
);

    if (WORD_WIDTH != 32) begin : g_bad_word_width
        $fatal(1, "decode_ctrl_stage: WORD_WIDTH must be 32");
    end
    if (ALU_CTRL_W < 4) begin : g_bad_alu_ctrl_w
        $fatal(1, "decode_ctrl_stage: ALU_CTRL_W must be at least 4");
    end
    if (REG_ADDR_W != 5) begin : g_bad_reg_addr_w
        $fatal(1, "decode_ctrl_stage: REG_ADDR_W must be 5");
    end

    ctrl_t            dec_ctrl;
    logic             dec_illegal;
    ctrl_t            ctrl_d, ctrl_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             cnt_inc;

    rv32i_ctrl_decode u_dec (
        .instr_i   (instrD[31:0]),
        .ctrl_o    (dec_ctrl),
        .imm_src_o (ImmSrcD),
        .illegal_o (dec_illegal)
    );

    assign illegalD = validD & dec_illegal;

    always_comb begin
        ctrl_d = ctrl_q;
        if (flushE) begin
            ctrl_d = BUBBLE;
        end else if (!stallE) begin
            ctrl_d = validD ? dec_ctrl : BUBBLE;
        end
    end

    assign cnt_inc = illegalD & ~stallE & ~flushE;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= BUBBLE;
            cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            cnt_q  <= cnt_d;
        end
    end

    assign validE        = ctrl_q.valid;
    assign regWriteE     = ctrl_q.reg_write;
    assign resultSrcE    = ctrl_q.result_src;
    assign memWriteE     = ctrl_q.mem_write;
    assign jumpE         = ctrl_q.jump;
    assign jalrE         = ctrl_q.jalr;
    assign branchE       = ctrl_q.branch;
    assign funct3E       = ctrl_q.funct3;
    assign ALUControlE   = ALU_CTRL_W'(ctrl_q.alu_ctrl);
    assign ALUSrcAE      = ctrl_q.alu_src_a;
    assign ALUSrcBE      = ctrl_q.alu_src_b;
    assign rdE           = REG_ADDR_W'(ctrl_q.rd);
    assign illegalE      = ctrl_q.illegal;
    assign illegal_count = cnt_q;

endmodule

// File: doc/decode_ctrl_stage.md
Name: decode_ctrl_stage

Overview:
Full RV32I control decoder fused with the ID/EX control pipeline register for the 5-stage core.
- Decodes the whole 32-bit instruction, not just op/funct fields: adds shifts, SLT/SLTU, LUI, AUIPC, JALR and illegal-instruction detection, with a wider ALU control code.
- Produces D-stage immediate select combinationally and registers all E-stage control.
- Handles stall/flush bubbles and keeps a saturating illegal-instruction counter.

Parameters:
WORD_WIDTH, 32, instruction/data width (fixed 32 for RV32I; checked by elaboration assert)
ALU_CTRL_W, 4, ALU control code width (minimum 4)
REG_ADDR_W, 5, register index width
CNT_W, 16, illegal-instruction counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
instrD  in  WORD_WIDTH  instruction in decode stage
validD  in  1  instrD holds a real instruction
stallE  in  1  hold ID/EX register
flushE  in  1  load bubble into ID/EX register
ImmSrcD  out  3  immediate type for D-stage extender (combinational)
illegalD  out  1  instrD is illegal (combinational, gated by validD)
validE  out  1  E-stage slot valid
regWriteE  out  1  register write enable
resultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
memWriteE  out  1  store enable
jumpE  out  1  JAL/JALR
jalrE  out  1  target = rs1+imm
branchE  out  1  conditional branch
funct3E  out  3  branch type / load-store width
ALUControlE  out  ALU_CTRL_W  ALU op code
ALUSrcAE  out  1  0 rs1, 1 PC
ALUSrcBE  out  1  0 rs2, 1 imm
rdE  out  REG_ADDR_W  destination register
illegalE  out  1  E-stage slot holds an illegal instruction
illegal_count  out  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001, PASSB 1010. Upper bits are zero when ALU_CTRL_W > 4.
- ImmSrc codes: I 000, S 001, B 010, J 011, U 100.
- Legal opcodes: 0000011 load, 0100011 store, 0110011 R, 0010011 I-ALU, 1100011 branch, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC. Any other opcode is illegal.
- Per-opcode illegal cases:
  - R-type: funct7 must be 0000000, or 0100000 with funct3 000/101.
  - I-shift (funct3 001/101): funct7 must be 0000000, or 0100000 only with funct3 101.
  - Branch: funct3 010/011 illegal.
  - JALR: funct3 must be 000.
  - Load: funct3 011/110/111 illegal.
  - Store: funct3 >= 011 illegal.
- SUB is selected only for R-type with funct7[5]=1. I-type ADDI never subtracts.
- Branch ALUControl is SUB.
- Load, store, JAL and JALR ALUControl is ADD.
- LUI: PASSB, ALUSrcB=1. AUIPC: ADD, ALUSrcA=1, ALUSrcB=1.
- JAL/JALR: resultSrc 10, regWrite 1.
- Write enables for rd: regWrite=0 for store and branch. regWrite is not suppressed when rd=x0; the register file ignores x0.
- ImmSrcD and illegalD are purely combinational on instrD/validD, with zero latency.
- Register update, priority reset > flush > stall > load:
  - reset or flushE: bubble. All E outputs are 0, including validE and illegalE.
  - stallE (without flush): all E outputs hold their value.
  - otherwise: E outputs take the decoded values of instrD after 1 cycle.
- validD=0 loads a bubble.
- Illegal instruction with validD=1 loads validE=1, illegalE=1, and regWrite/memWrite/jump/jalr/branch all 0. The other fields are don't-care but driven 0.
- illegal_count:
  - reset clears it to 0.
  - Increments by 1 on a cycle with validD & illegalD & !stallE & !flushE & !reset.
  - Saturates at all-ones and never wraps.
  - Stalled or flushed illegal instructions are not counted.
- Reset mid-stall or mid-flush: reset wins and all outputs are zero on the next edge.

Decomposition:
- Shared package decode_pkg holds:
  - opcode localparams;
  - alu_ctrl_e, imm_src_e and result_src_e enums;
  - ctrl_t packed struct bundling all E-stage control fields, with a BUBBLE constant.
- Sub-module rv32i_ctrl_decode: combinational. Maps instrD to ctrl_t, ImmSrcD and illegal.
- decode_ctrl_stage: instantiates rv32i_ctrl_decode and adds the ctrl_t register, the priority logic and the counter.

Test Plan:
- add x3,x1,x2 (0x002081B3), validD=1 -> next cycle regWriteE=1, ALUControlE=0000, ALUSrcBE=0, resultSrcE=00, rdE=3, validE=1. sub (0x402081B3) -> ALUControlE=0001.
- lw x5,8(x1) (0x0080A283) -> ImmSrcD=000 same cycle. Next cycle resultSrcE=01, ALUSrcBE=1, funct3E=010. sw x5,4(x1) (0x0050A223) -> ImmSrcD=001, memWriteE=1, regWriteE=0.
- lui x7,0x12345 (0x123453B7) -> ImmSrcD=100, ALUControlE=1010. auipc (0x00000297) -> ALUSrcAE=1, ALUControlE=0000. jalr x1,0(x2) (0x000100E7) -> jumpE=1, jalrE=1, resultSrcE=10.
- 0xFFFFFFFF, validD=1 for 3 cycles -> illegalE=1, regWriteE=0, memWriteE=0, illegal_count=3. Repeat with stallE=1 -> count unchanged. Preload counter near max (CNT_W=4 build, 17 illegals) -> holds at 0xF.
- add loaded, then stallE=1 for 2 cycles with sub on instrD -> E outputs stay add. Then flushE=1 together with stallE=1 -> validE=0 and all enables 0.
- reset asserted while stallE=1 and regWriteE=1 -> next edge all outputs 0 and illegal_count=0.
